list_buffer_ctrl: RTL

//  Linked-list controller for the shared ListBuffer data store. It keeps QUEUES

---
 rtl/list_buffer_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/list_buffer_ctrl.sv
// Linked-list controller: QUEUES independent FIFOs threaded through ENTRIES shared slots.
// Tracks head/tail/next pointers and slot occupancy; the data memory itself lives outside.
module list_buffer_ctrl #(
    parameter int QUEUES  = 2,
    parameter int ENTRIES = 4,
    parameter int QW      = (QUEUES  > 1) ? $clog2(QUEUES)  : 1,
    parameter int EW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_valid,
    input  logic [QW-1:0]     push_index,
    output logic              push_ready,
    output logic [EW-1:0]     push_addr,
    input  logic              pop_valid,
    input  logic [QW-1:0]     pop_index,
    output logic [EW-1:0]     pop_addr,
    output logic [QUEUES-1:0] q_valid,
    output logic [EW:0]       free_count,
    output logic              pop_err
);

    logic [ENTRIES-1:0] used_q, used_d;
    logic [QUEUES-1:0]  qv_q, qv_d;
    logic [EW-1:0]      head_q [QUEUES];
    logic [EW-1:0]      head_d [QUEUES];
    logic [EW-1:0]      tail_q [QUEUES];
    logic [EW-1:0]      tail_d [QUEUES];
    logic [EW-1:0]      next_q [ENTRIES];
    logic [EW-1:0]      next_d [ENTRIES];
    logic [EW:0]        free_q, free_d;
    logic               pop_err_q, pop_err_d;

    logic               push_fire;
    logic               pop_fire;
    logic [EW-1:0]      pop_head;
    logic               pop_single;
    logic               same_q_refill;

    // Lowest-index free slot; only pre-edge occupancy is visible to the allocator.
    always_comb begin
        push_ready = 1'b0;
        push_addr  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                push_ready = 1'b1;
                push_addr  = EW'(i);
            end
        end
    end

    assign pop_head      = head_q[pop_index];
    assign pop_addr      = pop_head;
    assign pop_single    = (pop_head == tail_q[pop_index]);
    assign push_fire     = push_valid & push_ready;
    assign pop_fire      = pop_valid & qv_q[pop_index];
    // A pop draining a single-element queue while the same queue is pushed restarts the list.
    assign same_q_refill = pop_fire & pop_single & (pop_index == push_index);

    always_comb begin
        used_d    = used_q;
        qv_d      = qv_q;
        head_d    = head_q;
        tail_d    = tail_q;
        next_d    = next_q;
        pop_err_d = pop_valid & ~qv_q[pop_index];
        free_d    = free_q - (EW+1)'(push_fire) + (EW+1)'(pop_fire);

        if (pop_fire) begin
            used_d[pop_head] = 1'b0;
            if (pop_single) begin
                qv_d[pop_index] = 1'b0;
            end else begin
                head_d[pop_index] = next_q[pop_head];
            end
        end

        if (push_fire) begin
            used_d[push_addr]  = 1'b1;
            tail_d[push_index] = push_addr;
            if (qv_q[push_index] && !same_q_refill) begin
                next_d[tail_q[push_index]] = push_addr;
            end else begin
                head_d[push_index] = push_addr;
                qv_d[push_index]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            used_q    <= '0;
            qv_q      <= '0;
            free_q    <= (EW+1)'(ENTRIES);
            pop_err_q <= 1'b0;
            for (int q = 0; q < QUEUES; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
            end
            for (int e = 0; e < ENTRIES; e++) begin
                next_q[e] <= '0;
            end
        end else begin
            used_q    <= used_d;
            qv_q      <= qv_d;
            free_q    <= free_d;
            pop_err_q <= pop_err_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            next_q    <= next_d;
        end
    end

    assign q_valid    = qv_q;
    assign free_count = free_q;
    assign pop_err    = pop_err_q;

endmodule
